// File: rtl/regfile_master_if.sv
// regfile_master_if: command, register-file port and response signals of regfile_master
// master modport: the regfile_master side (accepts commands, drives the regfile, returns responses)
// slave modport:  the environment side (command source, combinational register file, response sink)
interface regfile_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [4:0]  cmd_addr2;
  logic [31:0] cmd_data;
  logic [4:0]  r_addr_a;
  logic [4:0]  r_addr_b;
  logic [31:0] r_data_a;
  logic [31:0] r_data_b;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data_a;
  logic [31:0] rsp_data_b;
  logic        rsp_err;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_data, r_data_a, r_data_b, rsp_ready,
    output cmd_ready, r_addr_a, r_addr_b, w_addr, w_data, we, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_data, r_data_a, r_data_b, rsp_ready,
    input  cmd_ready, r_addr_a, r_addr_b, w_addr, w_data, we, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
  );
endinterface

// File: rtl/regfile_master.sv
// regfile_master: sequences READ2/WRITE/SWAP/INIT commands onto a 32x32 register file
// Ports: clk; reset (synchronous, active-high); bus (regfile_master_if.master) with the command
// channel (cmd_*), register-file read/write port (r_addr_*, r_data_*, w_addr, w_data, we active-low)
// and the response channel (rsp_*). Define REGFILE_MASTER_SWEEP_EN to make INIT fill all registers;
// without it INIT is answered with rsp_err and performs no write.
module regfile_master (
  input logic clk,
  input logic reset,
  regfile_master_if.master bus
);
  localparam logic [1:0] OP_READ2 = 2'b00, OP_WRITE = 2'b01, OP_SWAP = 2'b10, OP_INIT = 2'b11;
`ifdef REGFILE_MASTER_SWEEP_EN
  typedef enum logic [2:0] {IDLE, EXEC, SWAP1, SWAP2, RESP, SWEEP} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, SWAP1, SWAP2, RESP} state_t;
`endif
  state_t state, state_n;
  logic [1:0] op, op_n;
  logic [4:0] ra, rb, wa, ra_n, rb_n, wa_n;
  logic [31:0] wd, da, db, wd_n, da_n, db_n;
  logic we, err, we_n, err_n;
  assign bus.cmd_ready = state == IDLE && !reset;
  assign bus.rsp_valid = state == RESP;
  assign bus.r_addr_a = ra;
  assign bus.r_addr_b = rb;
  assign bus.w_addr = wa;
  assign bus.w_data = wd;
  assign bus.we = we;
  assign bus.rsp_data_a = da;
  assign bus.rsp_data_b = db;
  assign bus.rsp_err = err;
  // Every regfile-facing output is a register, so each state computes the values its successor drives.
  always_comb begin
    state_n = state;
    op_n = op;
    ra_n = ra;
    rb_n = rb;
    wa_n = wa;
    wd_n = wd;
    we_n = 1'b1;
    da_n = da;
    db_n = db;
    err_n = err;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        op_n = bus.cmd_op;
        ra_n = bus.cmd_addr;
        rb_n = bus.cmd_addr2;
        err_n = 1'b0;
        case (bus.cmd_op)
          OP_READ2, OP_SWAP: state_n = EXEC;
          OP_WRITE: begin
            we_n = 1'b0;
            wa_n = bus.cmd_addr;
            wd_n = bus.cmd_data;
            state_n = EXEC;
          end
          OP_INIT: begin
            da_n = '0;
            db_n = '0;
`ifdef REGFILE_MASTER_SWEEP_EN
            we_n = 1'b0;
            wa_n = '0;
            wd_n = bus.cmd_data;
            state_n = SWEEP;
`else
            err_n = 1'b1;
            state_n = RESP;
`endif
          end
        endcase
      end
      EXEC: begin
        // Read data here is pre-write: a WRITE commits at this same closing edge.
        da_n = bus.r_data_a;
        db_n = bus.r_data_b;
        we_n = op != OP_SWAP;
        wa_n = op == OP_SWAP ? ra : wa;
        wd_n = op == OP_SWAP ? bus.r_data_b : wd;
        state_n = op == OP_SWAP ? SWAP1 : RESP;
      end
      SWAP1: begin
        we_n = 1'b0;
        wa_n = rb;
        wd_n = da;
        state_n = SWAP2;
      end
      SWAP2: state_n = RESP;
`ifdef REGFILE_MASTER_SWEEP_EN
      // w_addr doubles as the sweep counter; it wraps back to 0 after the last register.
      SWEEP: begin
        we_n = wa == 5'd31;
        wa_n = wa + 5'd1;
        state_n = wa == 5'd31 ? RESP : SWEEP;
      end
`endif
      RESP: state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      op <= OP_READ2;
      ra <= '0;
      rb <= '0;
      wa <= '0;
      wd <= '0;
      we <= 1'b1;
      da <= '0;
      db <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      ra <= ra_n;
      rb <= rb_n;
      wa <= wa_n;
      wd <= wd_n;
      we <= we_n;
      da <= da_n;
      db <= db_n;
      err <= err_n;
    end
endmodule
